// File: rtl/rs_dec_arbiter.sv
// rs_dec_arbiter
//   Shares one RS decoder between two symbol sources at codeword granularity.
//   A channel is granted the decoder input for exactly N symbols; the block
//   generates the start/end-of-codeword framing, records the owner of every
//   granted codeword in a tag FIFO and steers decoder outputs back to it.
//
//   Build option: RS_ARB_STRICT_PRIO_EN -- when defined, channel 0 always wins
//   contention in IDLE; when undefined (default) contention is round-robin.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s0_*/s1_*                upstream symbol streams (valid/ready/symbol)
//   d_valid, d_symbol,
//   d_start_codeword,
//   d_end_codeword, d_in_ready   decoder input side
//   d_o_*                    decoder output strobes and symbol
//   m0_*/m1_*                per-channel demultiplexed decoder output
//   pending                  codewords in flight inside the decoder
//   tag_underflow            sticky: decoder output arrived with no owner
module rs_dec_arbiter #(
    parameter int WORD_LENGTH = 8,
    parameter int N           = 15,
    parameter int K           = 11,
    parameter int MAX_PENDING = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s0_valid,
    input  logic [WORD_LENGTH-1:0]         s0_symbol,
    output logic                           s0_ready,
    input  logic                           s1_valid,
    input  logic [WORD_LENGTH-1:0]         s1_symbol,
    output logic                           s1_ready,
    output logic                           d_valid,
    output logic [WORD_LENGTH-1:0]         d_symbol,
    output logic                           d_start_codeword,
    output logic                           d_end_codeword,
    input  logic                           d_in_ready,
    input  logic                           d_o_valid,
    input  logic                           d_o_start_codeword,
    input  logic                           d_o_end_codeword,
    input  logic                           d_o_error,
    input  logic [WORD_LENGTH-1:0]         d_o_symbol,
    output logic                           m0_valid,
    output logic                           m0_start,
    output logic                           m0_end,
    output logic                           m0_error,
    output logic [WORD_LENGTH-1:0]         m0_symbol,
    output logic                           m1_valid,
    output logic                           m1_start,
    output logic                           m1_end,
    output logic                           m1_error,
    output logic [WORD_LENGTH-1:0]         m1_symbol,
    output logic [$clog2(MAX_PENDING):0]   pending,
    output logic                           tag_underflow
);

    localparam int CNT_W = $clog2(N);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(MAX_PENDING);

    generate
        if (K >= N || MAX_PENDING < 2 || (1 << PTR_W) != MAX_PENDING) begin : g_bad_params
            $error("rs_dec_arbiter: need K < N and MAX_PENDING a power of 2, >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               xfer;
    logic               busy_ch;
    logic               pick1;

    // Tag FIFO: one bit per in-flight codeword naming its owner channel.
    logic               tag_mem_q [MAX_PENDING];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     pending_q;
    logic               underflow_q;
    logic               fifo_full, fifo_empty, push, pop, head;

    assign fifo_full  = (pending_q == FULL_CNT);
    assign fifo_empty = (pending_q == '0);

`ifdef RS_ARB_STRICT_PRIO_EN
    assign pick1 = !s0_valid;
`else
    logic last_q, last_d;
    // Under contention grant the channel that did not win last time.
    assign pick1 = (s0_valid && s1_valid) ? !last_q : s1_valid;
`endif

    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        d_valid  = 1'b0;
        d_symbol = '0;
        xfer     = 1'b0;
        busy_ch  = 1'b0;
`ifndef RS_ARB_STRICT_PRIO_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_full && (s0_valid || s1_valid))
                    state_d = pick1 ? BUSY1 : BUSY0;
            end
            BUSY0: begin
                d_valid  = s0_valid;
                d_symbol = s0_symbol;
                s0_ready = d_in_ready;
                xfer     = s0_valid && d_in_ready;
            end
            BUSY1: begin
                d_valid  = s1_valid;
                d_symbol = s1_symbol;
                s1_ready = d_in_ready;
                xfer     = s1_valid && d_in_ready;
                busy_ch  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The grant is released only after the last symbol of the codeword.
        if (xfer) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d   = '0;
                state_d = IDLE;
`ifndef RS_ARB_STRICT_PRIO_EN
                last_d  = busy_ch;
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign d_start_codeword = d_valid && (cnt_q == '0);
    assign d_end_codeword   = d_valid && (cnt_q == LAST_CNT);

    // Tag pushed on the first symbol of a codeword, popped on decoder end.
    assign push = xfer && (cnt_q == '0);
    assign pop  = d_o_valid && d_o_end_codeword && !fifo_empty;
    assign head = tag_mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= '0;
            underflow_q <= 1'b0;
`ifndef RS_ARB_STRICT_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifndef RS_ARB_STRICT_PRIO_EN
            last_q  <= last_d;
`endif
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   pending_q <= pending_q + (PTR_W + 1)'(1);
                2'b01:   pending_q <= pending_q - (PTR_W + 1)'(1);
                default: pending_q <= pending_q;
            endcase
            if (d_o_valid && fifo_empty) underflow_q <= 1'b1;
        end
    end

    // NOTE: the tag storage has no reset; entries are only read while the
    // occupancy count says they were written.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= busy_ch;
    end

    assign pending       = pending_q;
    assign tag_underflow = underflow_q;

    // Output routing: strobes go to the head-tag owner only; output with no
    // owner (empty FIFO) is dropped.
    assign m0_valid  = d_o_valid          && !fifo_empty && !head;
    assign m0_start  = d_o_start_codeword && !fifo_empty && !head;
    assign m0_end    = d_o_end_codeword   && !fifo_empty && !head;
    assign m0_error  = d_o_error          && !fifo_empty && !head;
    assign m1_valid  = d_o_valid          && !fifo_empty &&  head;
    assign m1_start  = d_o_start_codeword && !fifo_empty &&  head;
    assign m1_end    = d_o_end_codeword   && !fifo_empty &&  head;
    assign m1_error  = d_o_error          && !fifo_empty &&  head;
    assign m0_symbol = d_o_symbol;
    assign m1_symbol = d_o_symbol;

endmodule
